// File: rtl/bishift_ctrl.sv
// Command sequencer for a bidirectional serial shift register: serializes a word
// into the register over N clocks, then captures and returns its parallel output.
module bishift_ctrl #(
    parameter int WIDTH = 4,
    parameter int LENW  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [LENW-1:0]  cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             hold,
    output logic             sr_d,
    output logic             sr_en,
    output logic             sr_dir,
    input  logic [WIDTH-1:0] sr_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;

    localparam logic [LENW-1:0] LEN_MAX = LENW'(WIDTH);

    function automatic logic [LENW-1:0] sat_len(input logic [LENW-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    // dir=0 sends the low n bits MSB-first; dir=1 sends the high n bits LSB-first,
    // so both directions leave the field in place after n shifts.
    function automatic logic pick_bit(input logic [WIDTH-1:0] data,
                                      input logic [LENW-1:0]  n,
                                      input logic             dir,
                                      input logic [LENW-1:0]  k);
        logic [WIDTH-1:0] sh;
        if (dir)
            sh = data >> (WIDTH - int'(n) + int'(k));
        else
            sh = data >> (int'(n) - 1 - int'(k));
        return sh[0];
    endfunction

    state_t           state_q, state_nx;
    logic [LENW-1:0]  cnt_q, cnt_nx;
    logic [LENW-1:0]  n_q, n_nx;
    logic             dir_q, dir_nx;
    logic [WIDTH-1:0] data_q, data_nx;

    logic             sr_d_nx, sr_en_nx, sr_dir_nx;
    logic             cmd_ready_nx, busy_nx, rsp_valid_nx;
    logic [WIDTH-1:0] rsp_data_nx;

    logic             accept;
    logic [LENW-1:0]  len_sat;

    assign accept  = cmd_valid & cmd_ready;
    assign len_sat = sat_len(cmd_len);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (accept) state_nx = (len_sat != '0) ? SHIFT : CAPTURE;
            SHIFT:   if (cnt_q == n_q) state_nx = CAPTURE;
            CAPTURE: state_nx = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Every output is registered from the next-cycle view, so cnt_q counts
    // shift pulses already issued and the final pulse is the one in flight.
    always_comb begin
        cnt_nx       = cnt_q;
        n_nx         = n_q;
        dir_nx       = dir_q;
        data_nx      = data_q;
        sr_en_nx     = 1'b0;
        sr_d_nx      = sr_d;
        sr_dir_nx    = sr_dir;
        rsp_valid_nx = 1'b0;
        rsp_data_nx  = rsp_data;
        cmd_ready_nx = (state_nx == IDLE);
        busy_nx      = (state_nx != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    n_nx      = len_sat;
                    dir_nx    = cmd_dir;
                    data_nx   = cmd_data;
                    sr_dir_nx = cmd_dir;
                    cnt_nx    = '0;
                    if (len_sat != '0) begin
                        sr_en_nx = 1'b1;
                        sr_d_nx  = pick_bit(cmd_data, len_sat, cmd_dir, '0);
                        cnt_nx   = LENW'(1);
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != n_q && !hold) begin
                    sr_en_nx = 1'b1;
                    sr_d_nx  = pick_bit(data_q, n_q, dir_q, cnt_q);
                    cnt_nx   = cnt_q + LENW'(1);
                end
            end
            CAPTURE: begin
                rsp_data_nx  = sr_out;
                rsp_valid_nx = 1'b1;
            end
            RESP: begin
                rsp_valid_nx = ~rsp_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            n_q       <= '0;
            dir_q     <= 1'b0;
            data_q    <= '0;
            sr_d      <= 1'b0;
            sr_en     <= 1'b0;
            sr_dir    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            cnt_q     <= cnt_nx;
            n_q       <= n_nx;
            dir_q     <= dir_nx;
            data_q    <= data_nx;
            sr_d      <= sr_d_nx;
            sr_en     <= sr_en_nx;
            sr_dir    <= sr_dir_nx;
            cmd_ready <= cmd_ready_nx;
            busy      <= busy_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
        end
    end

endmodule

// File: tb/tb_bishift_ctrl.sv
// Bench for bishift_ctrl: a behavioural shift register closes the loop, and each
// command is checked against the field/stream/latency rules of the controller.
module tb_bishift_ctrl;
    localparam int WIDTH = 4;
    localparam int LENW  = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             cmd_valid, cmd_ready, cmd_dir;
    logic [LENW-1:0]  cmd_len;
    logic [WIDTH-1:0] cmd_data;
    logic             hold;
    logic             sr_d, sr_en, sr_dir;
    logic [WIDTH-1:0] sr_out;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    bishift_ctrl #(.WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .hold(hold),
        .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir), .sr_out(sr_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Controlled shift register, with a parallel preload for test setup.
    logic [WIDTH-1:0] sr;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    always @(posedge clk) begin
        if (ld)
            sr <= ld_val;
        else if (sr_en)
            sr <= sr_dir ? {sr_d, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sr_d};
    end
    assign sr_out = sr;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [WIDTH-1:0] v);
        @(negedge clk);
        ld = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cmd_ready"}, cmd_ready, 1);
        chk({pfx, "_sr_d"}, sr_d, 0);
        chk({pfx, "_sr_en"}, sr_en, 0);
        chk({pfx, "_sr_dir"}, sr_dir, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_data"}, rsp_data, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    // One full transaction. Cycle c=1 is the cycle right after the accept edge,
    // so c counts clocks from the cycle in which the handshake was presented.
    task automatic run_cmd(input logic d, input logic [LENW-1:0] len,
                           input logic [WIDTH-1:0] data, input int hold_at,
                           input int hold_len, input bit rnd, input int rsp_wait,
                           input int exp_lat, output logic [WIDTH-1:0] got);
        int n, mask, field, acc, en_cnt, gaps, c, rv_c, held;
        logic last_d;
        logic [WIDTH-1:0] old, exp_word, kept;
        n = (int'(len) > WIDTH) ? WIDTH : int'(len);
        mask = (1 << n) - 1;
        field = d ? (int'(data) >> (WIDTH - n)) : (int'(data) & mask);
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        old = sr;
        exp_word = d ? WIDTH'((int'(old) >> n) | (int'(data) & (mask << (WIDTH - n))))
                     : WIDTH'((int'(old) << n) | (int'(data) & mask));
        cmd_valid = 1'b1; cmd_dir = d; cmd_len = len; cmd_data = data;
        @(negedge clk);
        // Junk on the command bus while busy must be ignored.
        cmd_dir = ~d; cmd_data = ~data; cmd_len = LENW'($urandom_range(0, 7));
        acc = 0; en_cnt = 0; gaps = 0; rv_c = 0; held = 0; c = 1; last_d = 1'b0;
        while (c <= 100 && rv_c == 0) begin
            if (c == 1) begin
                chk("busy_after_accept", busy, 1);
                chk("ready_after_accept", cmd_ready, 0);
                chk("first_en", sr_en, (n > 0) ? 1 : 0);
            end
            if (sr_en) begin
                if (d) acc = acc | (int'(sr_d) << en_cnt);
                else   acc = (acc << 1) | int'(sr_d);
                en_cnt++;
                last_d = sr_d;
                chk("sr_dir", sr_dir, d);
            end else if (en_cnt > 0 && en_cnt < n) begin
                gaps++;
                chk("sr_d_frozen", sr_d, last_d);
            end
            if (rsp_valid) begin
                rv_c = c;
            end else begin
                if (rnd) hold = ($urandom_range(0, 2) == 0);
                else     hold = (hold_at > 0 && en_cnt == hold_at && held < hold_len);
                if (hold) held++;
                @(negedge clk);
                c++;
            end
        end
        hold = 1'b0;
        chk("rsp_seen", (rv_c != 0) ? 1 : 0, 1);
        chk("en_count", en_cnt, n);
        chk("bit_stream", acc, field);
        chk("latency_rule", rv_c, n + 2 + gaps);
        if (exp_lat > 0) chk("latency", rv_c, exp_lat);
        chk("rsp_data", rsp_data, exp_word);
        got = rsp_data;
        kept = rsp_data;
        for (int i = 0; i < rsp_wait; i++) begin
            hold = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rsp_valid_held", rsp_valid, 1);
            chk("rsp_data_stable", rsp_data, kept);
            chk("ready_low_in_resp", cmd_ready, 0);
            chk("busy_in_resp", busy, 1);
        end
        hold = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", rsp_valid, 0);
        chk("ready_back", cmd_ready, 1);
        chk("busy_cleared", busy, 0);
    endtask

    logic [WIDTH-1:0] got;

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0; cmd_data = '0;
        hold = 1'b0; rsp_ready = 1'b0; ld = 1'b0; ld_val = '0;
        preload(4'b0000);
        @(negedge clk);
        chk_reset_vals("rst");
        rstn = 1'b1;

        preload(4'b0000);
        run_cmd(1'b0, 3'd4, 4'b1011, 0, 0, 1'b0, 0, 6, got);
        chk("t1_word", got, 4'b1011);

        preload(4'b0110);
        run_cmd(1'b1, 3'd2, 4'b1000, 0, 0, 1'b0, 0, 4, got);
        chk("t2_word", got, 4'b1001);

        preload(4'b0101);
        run_cmd(1'b0, 3'd0, 4'b1111, 0, 0, 1'b0, 0, 2, got);
        chk("t3_word", got, 4'b0101);

        preload(4'b1001);
        run_cmd(1'b0, 3'd7, 4'b0110, 0, 0, 1'b0, 0, 6, got);
        chk("t4_word", got, 4'b0110);

        preload(4'b0000);
        run_cmd(1'b0, 3'd4, 4'b1100, 2, 3, 1'b0, 0, 9, got);
        chk("t5_word", got, 4'b1100);

        preload(4'b0000);
        run_cmd(1'b1, 3'd3, 4'b1010, 0, 0, 1'b0, 5, 5, got);
        chk("t6_word", got, 4'b1010);

        for (int r = 0; r < 20; r++) begin
            run_cmd(1'($urandom_range(0, 1)), LENW'($urandom_range(0, 7)),
                    WIDTH'($urandom), 0, 0, 1'b1, $urandom_range(0, 3), 0, got);
        end

        // Reset in the middle of a shift sequence.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 3'd4; cmd_data = 4'b1111;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("midshift_en", sr_en, 1);
        chk("midshift_busy", busy, 1);
        #2 rstn = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        rstn = 1'b1;

        preload(4'b0110);
        run_cmd(1'b0, 3'd2, 4'b0001, 0, 0, 1'b0, 0, 4, got);
        chk("post_reset_word", got, 4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bishift_ctrl.md
Name: bishift_ctrl

Overview:
- Command sequencer for the bidirectional serial shift register (ports d/en/dir/out, WIDTH bits).
- Accepts a parallel word, shift count and direction over a valid/ready handshake, then drives sr_d/sr_en/sr_dir for exactly that many clocks.
- After the last shift it captures the register's parallel output and returns it over a valid/ready response channel.
- Sits between a host/bus-side requester and one shift register instance.

Parameters:
- WIDTH, 4, bits in the controlled shift register; must be at least 2.
- LENW, 3, width of the shift-count field; must be at least $clog2(WIDTH+1).

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_dir  input  1  0 = shift toward MSB (d enters out[0]); 1 = shift toward LSB (d enters out[WIDTH-1]).
- cmd_len  input  LENW  number of shifts, N.
- cmd_data  input  WIDTH  word to serialize.
- hold  input  1  pause shifting while high.
- sr_d  output  1  to shift register d.
- sr_en  output  1  to shift register en.
- sr_dir  output  1  to shift register dir.
- sr_out  input  WIDTH  from shift register out.
- rsp_valid  output  1  response data available.
- rsp_ready  input  1  requester accepts the response.
- rsp_data  output  WIDTH  captured sr_out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous, active-low (rstn); deassertion is synchronous to clk at the integration level.
  - All outputs are registered.
- Reset values:
  - State = IDLE; cmd_ready = 1.
  - sr_d = 0, sr_en = 0, sr_dir = 0.
  - rsp_valid = 0, rsp_data = 0, busy = 0.
  - Internal counter and data latch are cleared.
- State machine: IDLE, SHIFT, CAPTURE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_dir/cmd_data. Latch N = min(cmd_len, WIDTH); values above WIDTH saturate.
  - If N > 0, go to SHIFT. If N = 0, go to CAPTURE (the response reads the current register contents).
- SHIFT:
  - Step counter k runs from 0 to N-1.
  - sr_en = ~hold.
  - sr_dir holds the latched dir for the whole command.
  - Bit presented at step k:
    - dir = 0: cmd_data[N-1-k]
    - dir = 1: cmd_data[WIDTH-N+k]
  - With this ordering, after N shifts the register holds those N bits in place: out[N-1:0] for dir = 0, out[WIDTH-1:WIDTH-N] for dir = 1. The other bits are the old contents, shifted.
  - k advances only on cycles with sr_en = 1.
  - While hold = 1, sr_en = 0, and sr_d and k are frozen.
  - After the edge that performs shift N-1, go to CAPTURE and drop sr_en.
  - sr_en is high for exactly N non-held cycles; it never glitches across states.
- CAPTURE:
  - Lasts one cycle, so the shift register output has settled.
  - rsp_data <= sr_out; go to RESP.
- RESP:
  - rsp_valid = 1. rsp_data stays stable until rsp_valid & rsp_ready.
  - On that handshake, return to IDLE; cmd_ready rises the next cycle.
- Latency:
  - Accept edge to first sr_en = 1 cycle: 1 clock.
  - Accept to rsp_valid = N + 2 clocks, with no hold.
- Handshake rules:
  - cmd_ready = 0 whenever busy. A cmd_valid in that window is ignored and must be held by the requester.
  - cmd_* inputs are sampled only on the accept edge; later changes have no effect.
  - hold has no effect in IDLE, CAPTURE or RESP.
- Reset mid-operation: returns immediately to IDLE with reset values. The shift register's contents are not restored.

Test Plan:
- WIDTH = 4, register pre-cleared, cmd dir=0, len=4, data=4'b1011 -> sr_d sequence 1,0,1,1; sr_en high for 4 cycles; rsp_valid at accept+6; rsp_data = 4'b1011.
- dir=1, len=2, data=4'b1000, register preloaded with 4'b0110 -> sr_d 0,1; rsp_data = 4'b1001.
- len=0 with register at 4'b0101 -> no sr_en pulse; rsp_valid at accept+2; rsp_data = 4'b0101.
- len=7 (saturates to 4), data=4'b0110, dir=0 -> exactly 4 en cycles; rsp_data = 4'b0110.
- dir=0, len=4, data=4'b1100, hold high for 3 cycles after the 2nd shift -> sr_en low for 3 cycles; sr_d frozen; total 4 en cycles; rsp_data = 4'b1100; rsp_valid at accept+9.
- rsp_ready held low for 5 cycles -> rsp_valid/rsp_data stable and cmd_ready stays 0. Then rstn pulsed low mid-SHIFT on the next command -> all outputs return to reset values asynchronously.
